// File: rtl/face_issue_pkg.sv
// Shared constants, run-state encoding and opcode classification for the
// FACE fetch/decode/issue front end.
package face_issue_pkg;

    localparam logic [6:0] SYSOPCODE = 7'h73;
    localparam logic [6:0] SHAOPCODE = 7'h0B;

    localparam int SYS_BIT = 2;
    localparam int SHA_BIT = 1;

    // Class masks are produced at this width and sliced to NUNITS by users.
    localparam int OP_MASK_W = 8;

    localparam int MAX_INSTR_W = 64;
    localparam logic [MAX_INSTR_W-1:0] NOP_INSTR  = '1;
    localparam logic [MAX_INSTR_W-1:0] HALT_INSTR = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [OP_MASK_W-1:0] op_class(input logic [6:0] opcode);
        logic [OP_MASK_W-1:0] mask;
        mask = '0;
        if (opcode == SYSOPCODE) mask[SYS_BIT] = 1'b1;
        if (opcode == SHAOPCODE) mask[SHA_BIT] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/face_instr_fifo.sv
// Prefetch FIFO: accepts 0..LANES instructions per cycle (lane 0 of push_data
// is the MSB slice and is stored first), pops one per cycle, exposes the head.
// Pointers carry an extra wrap bit so count = wr_ptr - rd_ptr covers full.
module face_instr_fifo #(
    parameter int W     = 32,
    parameter int LANES = 2,
    parameter int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int PTR_W = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [PTR_W-1:0]     push_cnt,
    input  logic [LANES*W-1:0]   push_data,
    input  logic                 pop,
    output logic [W-1:0]         head,
    output logic [PTR_W-1:0]     count
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointer update; flush empties the FIFO for a fresh run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + push_cnt;
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage write, lane 0 at the current write pointer.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int l = 0; l < LANES; l++) begin
                if (PTR_W'(l) < push_cnt)
                    mem[wr_ptr[AW-1:0] + AW'(l)] <= push_data[(LANES-1-l)*W +: W];
            end
        end
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/face_instr_issue.sv
// Fetch/decode/issue front end: credit-based ROM fetch into the prefetch FIFO,
// in-order single issue with per-class busy stall and a one-cycle shadow.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | fetching and issuing
//   DRAIN | HALT consumed, waiting for units and shadow to clear
//   DONE  | finished, done held high until next start
module face_instr_issue
    import face_issue_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int FETCH_W    = 64,
    parameter int ADDR_W     = 32,
    parameter int NUNITS     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_pc,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               rom_ren,
    input  logic [FETCH_W-1:0] rom_rdata,
    input  logic [NUNITS-1:0]  unit_busy,
    output logic [INSTR_W-1:0] instr_e,
    output logic               instr_valid,
    output logic               running,
    output logic               done,
    output logic [31:0]        stall_cnt
);

    localparam int LANES = FETCH_W / INSTR_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0]  STEP = ADDR_W'(FETCH_W / 8);
    localparam logic [INSTR_W-1:0] NOP  = NOP_INSTR[INSTR_W-1:0];
    localparam logic [INSTR_W-1:0] HALT = HALT_INSTR[INSTR_W-1:0];

    state_t                 state, state_nx;
    logic [ADDR_W-1:0]      fetch_ptr;
    logic                   rd_pend;
    logic                   halt_seen;
    logic                   halt_in_word;
    logic [PTR_W-1:0]       push_cnt;
    logic [PTR_W-1:0]       fifo_count;
    logic [PTR_W-1:0]       free_slots;
    logic                   credit_ok;
    logic [INSTR_W-1:0]     head;
    logic [OP_MASK_W-1:0]   cls_wide;
    logic [NUNITS-1:0]      classmask;
    logic [NUNITS-1:0]      shadow;
    logic                   fifo_empty, head_is_halt, blocked;
    logic                   can_issue, fifo_pop, stall_now, start_go;

    face_instr_fifo #(
        .W     (INSTR_W),
        .LANES (LANES),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (start_go),
        .push_cnt  (push_cnt),
        .push_data (rom_rdata),
        .pop       (fifo_pop),
        .head      (head),
        .count     (fifo_count)
    );

    // Returned word: push lanes up to and including the first HALT, drop the rest.
    always_comb begin
        push_cnt     = '0;
        halt_in_word = 1'b0;
        if (state == RUN && rd_pend && !halt_seen) begin
            push_cnt = PTR_W'(LANES);
            for (int l = 0; l < LANES; l++) begin
                if (!halt_in_word && rom_rdata[(LANES-1-l)*INSTR_W +: INSTR_W] == HALT) begin
                    halt_in_word = 1'b1;
                    push_cnt     = PTR_W'(l + 1);
                end
            end
        end
    end

    // A word in flight already owns LANES slots, so it is charged before a new request.
    assign free_slots = PTR_W'(FIFO_DEPTH) - fifo_count;
    assign credit_ok  = rd_pend ? (free_slots >= PTR_W'(2 * LANES))
                                : (free_slots >= PTR_W'(LANES));
    assign rom_ren    = (state == RUN) && !halt_seen && !halt_in_word && credit_ok;
    assign rom_addr   = fetch_ptr;

    assign cls_wide     = op_class(head[6:0]);
    assign classmask    = cls_wide[NUNITS-1:0];
    assign fifo_empty   = (fifo_count == '0);
    assign head_is_halt = (head == HALT);
    assign blocked      = |(classmask & (unit_busy | shadow));
    assign can_issue    = (state == RUN) && !fifo_empty && !head_is_halt && !blocked;
    assign fifo_pop     = can_issue || ((state == RUN) && !fifo_empty && head_is_halt);
    assign stall_now    = (state == RUN) && !fifo_empty && !head_is_halt && blocked;
    assign start_go     = start && (state == IDLE || state == DONE);
    assign running      = (state == RUN) || (state == DRAIN);

    // Run-control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Run-control next state.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: if (start) state_nx = RUN;
            RUN:        if (!fifo_empty && head_is_halt) state_nx = DRAIN;
            DRAIN:      if (unit_busy == '0 && shadow == '0) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // Fetch pointer, outstanding read and end-of-program tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_ptr <= '0;
            rd_pend   <= 1'b0;
            halt_seen <= 1'b0;
        end else if (start_go) begin
            fetch_ptr <= start_pc;
            rd_pend   <= 1'b0;
            halt_seen <= 1'b0;
        end else begin
            rd_pend <= rom_ren;
            if (rom_ren) fetch_ptr <= fetch_ptr + STEP;
            if (halt_in_word) halt_seen <= 1'b1;
        end
    end

    // Issue register; shadow covers the cycle before the unit can raise busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_e     <= NOP;
            instr_valid <= 1'b0;
            shadow      <= '0;
        end else if (can_issue) begin
            instr_e     <= head;
            instr_valid <= 1'b1;
            shadow      <= classmask;
        end else begin
            instr_e     <= NOP;
            instr_valid <= 1'b0;
            shadow      <= '0;
        end
    end

    // Stall counter and done flag, both cleared by an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            done      <= 1'b0;
        end else if (start_go) begin
            stall_cnt <= '0;
            done      <= 1'b0;
        end else begin
            if (stall_now && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (state == DRAIN && state_nx == DONE) done <= 1'b1;
        end
    end

endmodule
